alu_op_sequencer: RTL
=====================

Name: alu_op_sequencer

Overview:
- Multi-cycle control FSM that sequences one register-to-register ALU operation at a time over the shared single-bus datapath.
- Steps per operation: operand A into Y, operand B onto the bus with the ALU code applied, result captured in Z (64-bit), then written back.
  - 32-bit ops: Z low word to the destination register.
  - mul/div: Z low word to LO, Z high word to HI.
- Sits between instruction decode (request side) and the datapath enables (register file, Y, Z, HI, LO).

Parameters:
- MD_WAIT_CYCLES, 2, extra settle cycles held in EXEC before Z is captured for mul (1000) and div (1001); 0..15.
- REG_IDX_W, 4, register index width (16 GPRs).

Ports:
- clk  input  1  rising-edge clock
- clr  input  1  asynchronous active-high reset
- req_valid  input  1  decode presents an operation
- req_ready  output  1  sequencer can accept (high only in IDLE)
- req_op  input  4  ALU code: 0000 and … 1011 not; 1100-1111 illegal
- req_ra  input  REG_IDX_W  destination register
- req_rb  input  REG_IDX_W  operand A register
- req_rc  input  REG_IDX_W  operand B register
- alu_ctrl  output  4  ALU control code
- rf_rd_en  output  1  register file drives bus
- rf_rd_sel  output  REG_IDX_W  register driving bus
- rf_wr_en  output  1  register file write
- rf_wr_sel  output  REG_IDX_W  register written
- y_in  output  1  load Y from bus
- z_in  output  1  load Z (64-bit) from ALU
- zlo_out  output  1  Z[31:0] drives bus
- zhi_out  output  1  Z[63:32] drives bus
- lo_in  output  1  load LO from bus
- hi_in  output  1  load HI from bus
- done  output  1  one-cycle pulse: operation retired
- err  output  1  one-cycle pulse with done: illegal op

Behaviour:
- clr asserted, including mid-operation: state goes to IDLE; op, ra, rb, rc and wait counter are cleared.
  - All outputs are 0 during reset except req_ready.
  - req_ready = 1 once in IDLE.
  - No partial write-back completes.
- Outputs are Moore functions of state and latched fields. alu_ctrl = latched op in EXEC, else 0000.
- States:
  - IDLE: req_ready = 1. When req_valid is high, latch op/ra/rb/rc.
    - Next state: ERR if op ≥ 1100; EXEC if op is 1010 or 1011 (B-only); otherwise RD_A.
  - RD_A: rf_rd_en = 1, rf_rd_sel = rb, y_in = 1. Next: EXEC.
  - EXEC: rf_rd_en = 1, rf_rd_sel = rc, alu_ctrl = op.
    - Non-mul/div ops: z_in = 1 for one cycle; next WB.
    - mul/div: stay 1 + MD_WAIT_CYCLES cycles (counter reloads on entry). z_in = 1 only on the final cycle; next WB_LO.
  - WB: zlo_out = 1, rf_wr_en = 1, rf_wr_sel = ra, done = 1. Next: IDLE.
  - WB_LO: zlo_out = 1, lo_in = 1. Next: WB_HI.
  - WB_HI: zhi_out = 1, hi_in = 1, done = 1. Next: IDLE.
  - ERR: done = 1, err = 1, no datapath enables. Next: IDLE.
- Latency from the accept cycle (cycle 0):
  - Regular op: done in cycle 3.
  - neg/not: done in cycle 2.
  - mul/div: done in cycle 4 + MD_WAIT_CYCLES.
  - Illegal op: done in cycle 1.
- One operation in flight. Requests are ignored while req_ready = 0, and req_* may change freely then.
- A new request is accepted in the IDLE cycle right after done; no back-to-back overlap.
- Mutual exclusion: at most one bus driver per cycle (rf_rd_en, zlo_out, zhi_out).
- ra = rb or ra = rc is legal; write-back occurs after both reads.

Optional Feature:
- ALU_SEQ_PERF_EN defined: adds two outputs, both cleared by clr.
  - perf_ops[31:0]: increments on every done with err = 0.
  - perf_busy[31:0]: increments every cycle state ≠ IDLE.
  - Both wrap at 2^32.
- Not defined: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Shared package:
  - 4-bit ALU op code constants (AND..NOT).
  - Helper classifications: is_muldiv, is_b_only, is_illegal.
  - State enum (IDLE, RD_A, EXEC, WB, WB_LO, WB_HI, ERR).
- No sub-module is needed. The MD wait counter is inline (4 bits).

Test Plan:
- Reset mid-operation: assert clr during EXEC of an add → all enables 0 and req_ready = 1 the same cycle; no rf_wr_en ever pulses.
- add R3 = R1 + R2 with R1 = 5, R2 = 7 → y_in cycle 1 (sel 1); z_in with alu_ctrl 0010 cycle 2 (sel 2); rf_wr_en with sel 3 and done cycle 3; model R3 = 12.
- mul R1 × R2 with R1 = 0x0001_0000, R2 = 0x0003_0000, MD_WAIT_CYCLES = 2 → EXEC lasts 3 cycles with z_in only on the last; LO = 0x0000_0000, HI = 0x0000_0003; done cycle 6; rf_wr_en never asserted.
- neg R4 = -R2 with R2 = 1 → no y_in; EXEC cycle 1 with alu_ctrl 1010; done cycle 2; R4 = 0xFFFF_FFFF.
- Illegal op 1101 → done = err = 1 in cycle 1; no enables; next request accepted cycle 2.
- req_valid held high continuously with 3 queued adds → accepts only in IDLE, spaced 4 cycles apart; each done single-cycle; with ALU_SEQ_PERF_EN, perf_ops = 3 and perf_busy = 9.

Source files
------------

// File: rtl/alu_op_sequencer_pkg.sv
// Shared definitions for the ALU operation sequencer: op codes, FSM states
// and op classification helpers.
package alu_op_sequencer_pkg;

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SUB  = 4'b0011;
  localparam logic [3:0] OP_SHR  = 4'b0100;
  localparam logic [3:0] OP_SHRA = 4'b0101;
  localparam logic [3:0] OP_SHL  = 4'b0110;
  localparam logic [3:0] OP_ROR  = 4'b0111;
  localparam logic [3:0] OP_MUL  = 4'b1000;
  localparam logic [3:0] OP_DIV  = 4'b1001;
  localparam logic [3:0] OP_NEG  = 4'b1010;
  localparam logic [3:0] OP_NOT  = 4'b1011;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_A,
    S_EXEC,
    S_WB,
    S_WB_LO,
    S_WB_HI,
    S_ERR
  } state_t;

  function automatic logic is_muldiv(input logic [3:0] op);
    return (op == OP_MUL) || (op == OP_DIV);
  endfunction

  function automatic logic is_b_only(input logic [3:0] op);
    return (op == OP_NEG) || (op == OP_NOT);
  endfunction

  // Codes 1100-1111 are unassigned.
  function automatic logic is_illegal(input logic [3:0] op);
    return op[3:2] == 2'b11;
  endfunction

endpackage

// File: rtl/alu_op_sequencer_if.sv
// Request handshake from decode plus datapath enables driven by the sequencer.
// The slave modport is the sequencer's view; master is decode/datapath.
interface alu_op_sequencer_if #(
  parameter int REG_IDX_W = 4
);
  logic                 req_valid;
  logic                 req_ready;
  logic [3:0]           req_op;
  logic [REG_IDX_W-1:0] req_ra;
  logic [REG_IDX_W-1:0] req_rb;
  logic [REG_IDX_W-1:0] req_rc;
  logic [3:0]           alu_ctrl;
  logic                 rf_rd_en;
  logic [REG_IDX_W-1:0] rf_rd_sel;
  logic                 rf_wr_en;
  logic [REG_IDX_W-1:0] rf_wr_sel;
  logic                 y_in;
  logic                 z_in;
  logic                 zlo_out;
  logic                 zhi_out;
  logic                 lo_in;
  logic                 hi_in;
  logic                 done;
  logic                 err;

  modport master (
    output req_valid, req_op, req_ra, req_rb, req_rc,
    input  req_ready, alu_ctrl, rf_rd_en, rf_rd_sel, rf_wr_en, rf_wr_sel,
           y_in, z_in, zlo_out, zhi_out, lo_in, hi_in, done, err
  );

  modport slave (
    input  req_valid, req_op, req_ra, req_rb, req_rc,
    output req_ready, alu_ctrl, rf_rd_en, rf_rd_sel, rf_wr_en, rf_wr_sel,
           y_in, z_in, zlo_out, zhi_out, lo_in, hi_in, done, err
  );
endinterface

// File: rtl/alu_op_sequencer.sv
// Multi-cycle sequencer for one register-to-register ALU op on a single-bus
// datapath. Define ALU_SEQ_PERF_EN to add perf_ops/perf_busy counters.
//   state  | meaning
//   IDLE   | ready for a request, latch fields on req_valid
//   RD_A   | operand A (rb) onto bus, load Y
//   EXEC   | operand B (rc) onto bus, ALU applied, Z captured on last cycle
//   WB     | Z low word written to ra, done
//   WB_LO  | Z low word into LO
//   WB_HI  | Z high word into HI, done
//   ERR    | illegal op retired with done + err
module alu_op_sequencer
  import alu_op_sequencer_pkg::*;
#(
  parameter int MD_WAIT_CYCLES = 2,
  parameter int REG_IDX_W      = 4
) (
  input  logic        clk,
  input  logic        clr,
`ifdef ALU_SEQ_PERF_EN
  output logic [31:0] perf_ops,
  output logic [31:0] perf_busy,
`endif
  alu_op_sequencer_if.slave bus
);

  localparam logic [3:0] MD_W = 4'(MD_WAIT_CYCLES);

  state_t               state;
  logic [3:0]           op;
  logic [REG_IDX_W-1:0] ra;
  logic [REG_IDX_W-1:0] rb;
  logic [REG_IDX_W-1:0] rc;
  logic [3:0]           cnt;

  // Outputs are registered with the value belonging to the state being entered,
  // so they behave as Moore outputs of the current state.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state         <= S_IDLE;
      op            <= '0;
      ra            <= '0;
      rb            <= '0;
      rc            <= '0;
      cnt           <= '0;
      bus.req_ready <= 1'b1;
      bus.alu_ctrl  <= '0;
      bus.rf_rd_en  <= 1'b0;
      bus.rf_rd_sel <= '0;
      bus.rf_wr_en  <= 1'b0;
      bus.rf_wr_sel <= '0;
      bus.y_in      <= 1'b0;
      bus.z_in      <= 1'b0;
      bus.zlo_out   <= 1'b0;
      bus.zhi_out   <= 1'b0;
      bus.lo_in     <= 1'b0;
      bus.hi_in     <= 1'b0;
      bus.done      <= 1'b0;
      bus.err       <= 1'b0;
    end else begin
      bus.req_ready <= 1'b0;
      bus.alu_ctrl  <= '0;
      bus.rf_rd_en  <= 1'b0;
      bus.rf_rd_sel <= '0;
      bus.rf_wr_en  <= 1'b0;
      bus.rf_wr_sel <= '0;
      bus.y_in      <= 1'b0;
      bus.z_in      <= 1'b0;
      bus.zlo_out   <= 1'b0;
      bus.zhi_out   <= 1'b0;
      bus.lo_in     <= 1'b0;
      bus.hi_in     <= 1'b0;
      bus.done      <= 1'b0;
      bus.err       <= 1'b0;

      case (state)
        S_IDLE: begin
          if (bus.req_valid) begin
            op <= bus.req_op;
            ra <= bus.req_ra;
            rb <= bus.req_rb;
            rc <= bus.req_rc;
            if (is_illegal(bus.req_op)) begin
              state    <= S_ERR;
              bus.done <= 1'b1;
              bus.err  <= 1'b1;
            end else if (is_b_only(bus.req_op)) begin
              state         <= S_EXEC;
              cnt           <= MD_W;
              bus.rf_rd_en  <= 1'b1;
              bus.rf_rd_sel <= bus.req_rc;
              bus.alu_ctrl  <= bus.req_op;
              bus.z_in      <= 1'b1;
            end else begin
              state         <= S_RD_A;
              bus.rf_rd_en  <= 1'b1;
              bus.rf_rd_sel <= bus.req_rb;
              bus.y_in      <= 1'b1;
            end
          end else begin
            bus.req_ready <= 1'b1;
          end
        end

        S_RD_A: begin
          state         <= S_EXEC;
          cnt           <= MD_W;
          bus.rf_rd_en  <= 1'b1;
          bus.rf_rd_sel <= rc;
          bus.alu_ctrl  <= op;
          bus.z_in      <= !is_muldiv(op) || (MD_W == 4'd0);
        end

        S_EXEC: begin
          if (is_muldiv(op) && (cnt != 4'd0)) begin
            // Settle time for the multi-cycle units; Z is captured on the last pass.
            cnt           <= cnt - 4'd1;
            bus.rf_rd_en  <= 1'b1;
            bus.rf_rd_sel <= rc;
            bus.alu_ctrl  <= op;
            bus.z_in      <= (cnt == 4'd1);
          end else if (is_muldiv(op)) begin
            state       <= S_WB_LO;
            bus.zlo_out <= 1'b1;
            bus.lo_in   <= 1'b1;
          end else begin
            state         <= S_WB;
            bus.zlo_out   <= 1'b1;
            bus.rf_wr_en  <= 1'b1;
            bus.rf_wr_sel <= ra;
            bus.done      <= 1'b1;
          end
        end

        S_WB_LO: begin
          state       <= S_WB_HI;
          bus.zhi_out <= 1'b1;
          bus.hi_in   <= 1'b1;
          bus.done    <= 1'b1;
        end

        S_WB, S_WB_HI, S_ERR: begin
          state         <= S_IDLE;
          bus.req_ready <= 1'b1;
        end

        default: begin
          state         <= S_IDLE;
          bus.req_ready <= 1'b1;
        end
      endcase
    end
  end

`ifdef ALU_SEQ_PERF_EN
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      perf_ops  <= '0;
      perf_busy <= '0;
    end else begin
      if (bus.done && !bus.err) perf_ops <= perf_ops + 32'd1;
      if (state != S_IDLE) perf_busy <= perf_busy + 32'd1;
    end
  end
`endif

endmodule
